// File: rtl/data_memory_pipe.sv
// Word-addressed data memory with a valid/ready request port, per-byte write
// enables, out-of-range detection, post-reset init fill and 1- or 2-cycle read latency.
module data_memory_pipe #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    ADX_LENGTH  = 11,
  parameter int                    DATA_LENGTH = 2048,
  parameter int                    READ_LAT    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [ADX_LENGTH-1:0]   req_adx,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_err,
  output logic                    init_busy
);

  localparam int                    LANES    = DATA_WIDTH / 8;
  localparam logic [ADX_LENGTH-1:0] LAST_ADX = ADX_LENGTH'(DATA_LENGTH - 1);
  // One extra bit so a fully populated address space still compares correctly.
  localparam logic [ADX_LENGTH:0]   DEPTH    = (ADX_LENGTH + 1)'(DATA_LENGTH);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [ADX_LENGTH-1:0]   init_cnt_r;
  logic                    ready_r;
  logic                    busy_r;
  logic [DATA_WIDTH-1:0]   mem_r [DATA_LENGTH];

  logic                    accept_s;
  logic                    in_range_s;
  logic                    wr_en_s;
  logic [ADX_LENGTH-1:0]   wr_adx_s;
  logic [DATA_WIDTH-1:0]   wr_data_s;
  logic [LANES-1:0]        wr_be_s;

  logic                    s1_valid_r;
  logic                    s1_err_r;
  logic [DATA_WIDTH-1:0]   s1_data_r;

  // Next-state and array write-port selection (init fill vs. request write).
  always_comb begin
    state_s    = state_r;
    wr_en_s    = 1'b0;
    wr_adx_s   = init_cnt_r;
    wr_data_s  = INIT_VALUE;
    wr_be_s    = '1;
    accept_s   = req_valid & ready_r;
    in_range_s = ({1'b0, req_adx} < DEPTH);
    case (state_r)
      ST_INIT: begin
        wr_en_s = 1'b1;
        if (init_cnt_r == LAST_ADX) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_RUN: begin
        if (accept_s && req_wr && in_range_s) begin
          wr_en_s   = 1'b1;
          wr_adx_s  = req_adx;
          wr_data_s = req_wdata;
          wr_be_s   = req_be;
        end else begin
          wr_en_s   = 1'b0;
        end
      end
      default: begin
        state_s = ST_INIT;
      end
    endcase
  end

  // State register, init counter and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_INIT;
      init_cnt_r <= '0;
      ready_r    <= 1'b0;
      busy_r     <= 1'b1;
    end else begin
      state_r <= state_s;
      if (state_r == ST_INIT) begin
        init_cnt_r <= init_cnt_r + 1'b1;
      end else begin
        init_cnt_r <= '0;
      end
      ready_r <= (state_s == ST_RUN);
      busy_r  <= (state_s == ST_INIT);
    end
  end

  // Storage array; contents survive reset and are refilled by the init sequencer.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be_s[i]) begin
          mem_r[wr_adx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
        end
      end
    end
  end

  // First response stage: array read register; data/err hold between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_r <= 1'b0;
      s1_err_r   <= 1'b0;
      s1_data_r  <= '0;
    end else begin
      s1_valid_r <= accept_s & (~req_wr | ~in_range_s);
      if (accept_s && !in_range_s) begin
        s1_err_r  <= 1'b1;
        s1_data_r <= '0;
      end else if (accept_s && !req_wr) begin
        s1_err_r  <= 1'b0;
        s1_data_r <= mem_r[req_adx];
      end else begin
        s1_err_r  <= s1_err_r;
        s1_data_r <= s1_data_r;
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic                  s2_valid_r;
      logic                  s2_err_r;
      logic [DATA_WIDTH-1:0] s2_data_r;

      // Optional output register stage for the two-cycle read latency.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s2_valid_r <= 1'b0;
          s2_err_r   <= 1'b0;
          s2_data_r  <= '0;
        end else begin
          s2_valid_r <= s1_valid_r;
          if (s1_valid_r) begin
            s2_err_r  <= s1_err_r;
            s2_data_r <= s1_data_r;
          end else begin
            s2_err_r  <= s2_err_r;
            s2_data_r <= s2_data_r;
          end
        end
      end

      assign rsp_valid = s2_valid_r;
      assign rsp_err   = s2_err_r;
      assign rsp_data  = s2_data_r;
    end else begin : g_lat1
      assign rsp_valid = s1_valid_r;
      assign rsp_err   = s1_err_r;
      assign rsp_data  = s1_data_r;
    end
  endgenerate

  assign req_ready = ready_r;
  assign init_busy = busy_r;

endmodule

// File: tb/tb_data_memory_pipe.sv
// Directed bench: instance a (2048 words, READ_LAT=1) and instance b
// (1500 words, READ_LAT=2) share one request stream with separate expectations.
module tb_data_memory_pipe;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_wr;
  logic [10:0] req_adx;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;

  logic        a_req_ready, a_rsp_valid, a_rsp_err, a_init_busy;
  logic [15:0] a_rsp_data;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_init_busy;
  logic [15:0] b_rsp_data;

  int errors = 0;
  int checks = 0;

  data_memory_pipe u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_wr(req_wr), .req_adx(req_adx), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err),
    .init_busy(a_init_busy)
  );

  data_memory_pipe #(.DATA_LENGTH(1500), .READ_LAT(2)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_wr(req_wr), .req_adx(req_adx), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
    .init_busy(b_init_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [15:0] d, input logic e,
                         input logic [15:0] exp_d, input logic exp_e);
    chk({tag, "_valid"}, 32'(v), 32'd1);
    chk({tag, "_data"}, 32'(d), 32'(exp_d));
    chk({tag, "_err"}, 32'(e), 32'(exp_e));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_be    = 2'b00;
  endtask

  task automatic rd(input logic [10:0] adx, input logic [15:0] a_d, input logic a_e,
                    input logic [15:0] b_d, input logic b_e);
    req_valid = 1'b1; req_wr = 1'b0; req_adx = adx;
    tick(); idle();
    chk_rsp("rd_a", a_rsp_valid, a_rsp_data, a_rsp_err, a_d, a_e);
    chk("rd_b_early", 32'(b_rsp_valid), 32'd0);
    tick();
    chk("rd_a_single", 32'(a_rsp_valid), 32'd0);
    chk_rsp("rd_b", b_rsp_valid, b_rsp_data, b_rsp_err, b_d, b_e);
  endtask

  task automatic wr(input logic [10:0] adx, input logic [15:0] d, input logic [1:0] be,
                    input logic b_err);
    req_valid = 1'b1; req_wr = 1'b1; req_adx = adx; req_wdata = d; req_be = be;
    tick(); idle();
    chk("wr_a_norsp", 32'(a_rsp_valid), 32'd0);
    chk("wr_b_early", 32'(b_rsp_valid), 32'd0);
    tick();
    chk("wr_a_norsp2", 32'(a_rsp_valid), 32'd0);
    if (b_err) begin
      chk_rsp("wr_b_oor", b_rsp_valid, b_rsp_data, b_rsp_err, 16'h0000, 1'b1);
    end else begin
      chk("wr_b_norsp", 32'(b_rsp_valid), 32'd0);
    end
  endtask

  task automatic init_wait();
    int na;
    int nb;
    logic bad;
    na = 0; nb = 0; bad = 1'b0;
    for (int n = 1; n <= 2100; n++) begin
      tick();
      if (na == 0 && !a_init_busy) na = n;
      if (nb == 0 && !b_init_busy) nb = n;
      if ((na != 0 && a_init_busy) || (nb != 0 && b_init_busy)) bad = 1'b1;
      if (a_req_ready !== !a_init_busy || b_req_ready !== !b_init_busy) bad = 1'b1;
      if (n < 1500 && (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0)) bad = 1'b1;
    end
    chk("a_init_cycles", 32'(na), 32'd2048);
    chk("b_init_cycles", 32'(nb), 32'd1500);
    chk("init_ready_busy_resp", 32'(bad), 32'd0);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; req_adx = '0; req_wdata = '0;
    idle();
    #12;
    chk("rst_a_ready", 32'(a_req_ready), 32'd0);
    chk("rst_a_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_a_data", 32'(a_rsp_data), 32'd0);
    chk("rst_a_err", 32'(a_rsp_err), 32'd0);
    chk("rst_a_busy", 32'(a_init_busy), 32'd1);
    chk("rst_b_ready", 32'(b_req_ready), 32'd0);
    chk("rst_b_valid", 32'(b_rsp_valid), 32'd0);
    chk("rst_b_busy", 32'(b_init_busy), 32'd1);
    tick();
    rst = 1'b1;
    init_wait();

    // Top word: in range for a, out of range for b.
    rd(11'h7FF, 16'h0000, 1'b0, 16'h0000, 1'b1);

    // Write followed immediately by a read of the same word.
    req_valid = 1'b1; req_wr = 1'b1; req_adx = 11'h010; req_wdata = 16'hABCD; req_be = 2'b11;
    tick();
    chk("wrrd_a_norsp", 32'(a_rsp_valid), 32'd0);
    req_wr = 1'b0;
    tick(); idle();
    chk_rsp("wrrd_a", a_rsp_valid, a_rsp_data, a_rsp_err, 16'hABCD, 1'b0);
    chk("wrrd_b_early", 32'(b_rsp_valid), 32'd0);
    tick();
    chk("wrrd_a_single", 32'(a_rsp_valid), 32'd0);
    chk_rsp("wrrd_b", b_rsp_valid, b_rsp_data, b_rsp_err, 16'hABCD, 1'b0);

    // Byte lanes.
    wr(11'h020, 16'h1234, 2'b11, 1'b0);
    wr(11'h020, 16'hFF00, 2'b10, 1'b0);
    rd(11'h020, 16'hFF34, 1'b0, 16'hFF34, 1'b0);
    wr(11'h020, 16'h0000, 2'b00, 1'b0);
    rd(11'h020, 16'hFF34, 1'b0, 16'hFF34, 1'b0);
    wr(11'h020, 16'hAA55, 2'b01, 1'b0);
    rd(11'h020, 16'hFF55, 1'b0, 16'hFF55, 1'b0);

    // Out of range on b (1500 words); a is fully populated.
    rd(11'd1500, 16'h0000, 1'b0, 16'h0000, 1'b1);
    wr(11'd1600, 16'h5555, 2'b11, 1'b1);
    rd(11'd1600, 16'h5555, 1'b0, 16'h0000, 1'b1);
    wr(11'd1600, 16'h1111, 2'b00, 1'b1);
    rd(11'd1499, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // Streaming back-to-back reads.
    wr(11'd1, 16'h0001, 2'b11, 1'b0);
    wr(11'd2, 16'h0002, 2'b11, 1'b0);
    wr(11'd3, 16'h0003, 2'b11, 1'b0);
    req_valid = 1'b1; req_wr = 1'b0; req_adx = 11'd1;
    tick(); req_adx = 11'd2;
    chk_rsp("st_a1", a_rsp_valid, a_rsp_data, a_rsp_err, 16'h0001, 1'b0);
    chk("st_b0", 32'(b_rsp_valid), 32'd0);
    tick(); req_adx = 11'd3;
    chk_rsp("st_a2", a_rsp_valid, a_rsp_data, a_rsp_err, 16'h0002, 1'b0);
    chk_rsp("st_b1", b_rsp_valid, b_rsp_data, b_rsp_err, 16'h0001, 1'b0);
    tick(); idle();
    chk_rsp("st_a3", a_rsp_valid, a_rsp_data, a_rsp_err, 16'h0003, 1'b0);
    chk_rsp("st_b2", b_rsp_valid, b_rsp_data, b_rsp_err, 16'h0002, 1'b0);
    tick();
    chk("st_a_end", 32'(a_rsp_valid), 32'd0);
    chk_rsp("st_b3", b_rsp_valid, b_rsp_data, b_rsp_err, 16'h0003, 1'b0);
    tick();
    chk("st_b_end", 32'(b_rsp_valid), 32'd0);

    // Reset with a read in flight.
    req_valid = 1'b1; req_wr = 1'b0; req_adx = 11'h010;
    tick(); idle();
    chk("inflight_a_valid", 32'(a_rsp_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_a_valid", 32'(a_rsp_valid), 32'd0);
    chk("mid_rst_b_valid", 32'(b_rsp_valid), 32'd0);
    chk("mid_rst_a_busy", 32'(a_init_busy), 32'd1);
    chk("mid_rst_a_ready", 32'(a_req_ready), 32'd0);
    tick(); tick();
    rst = 1'b1;

    // Reset again at init word 100.
    for (int k = 0; k < 100; k++) tick();
    chk("init100_busy", 32'(a_init_busy), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    init_wait();
    rd(11'h010, 16'h0000, 1'b0, 16'h0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
